dm_store_buffer: RTL and testbench
==================================

# dm_store_buffer

Word-granular store buffer sitting directly upstream of the data memory in the MIPS core. It accepts committed stores from the MEM stage, holds them in a small FIFO, and drains one per cycle into the data memory write port (write-enable, address, write data, PC for the store trace). Loads can hit pending stores through youngest-match forwarding, so the pipeline stalls only on a full buffer.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept; a store is taken when st_valid & st_ready at the edge
- st_addr  in  AW  byte address; bits [1:0] ignored
- st_data  in  DW  store word
- st_pc  in  32  PC of the storing instruction, carried to the trace
- ld_addr  in  AW  load address for forwarding lookup
- ld_hit  out  1  a pending store matches ld_addr[AW-1:2]
- ld_data  out  DW  data of the youngest matching entry; 0 when no hit
- drain_en  in  1  memory write port free this cycle
- dm_we  out  1  write strobe to the data memory
- dm_addr  out  AW  head entry address
- dm_wd  out  DW  head entry data
- dm_pc  out  32  head entry PC
- sb_empty  out  1  no pending stores
- sb_count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Circular FIFO: head pointer, tail pointer, and a count register sized to reach DEPTH.
- Push: st_valid & st_ready writes {addr, data, pc} at tail; tail increments modulo DEPTH.
- Pop: dm_we = !sb_empty & drain_en; at the edge, head increments modulo DEPTH.
- dm_addr/dm_wd/dm_pc are combinational from the head entry; when empty they are 0.
- st_ready = (count != DEPTH). A full buffer does not accept a push, even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: count is unchanged; both pointers advance.
- Forwarding: compare ld_addr[AW-1:2] against every valid entry. On multiple matches, the entry closest to tail (youngest) wins. A store that is being pushed this cycle is not visible until the next cycle.
- Same-address stores are never merged; each store drains separately and in order.

## Timing
- Reset (async assert, synchronous-to-clk deassert use): count=0, head=tail=0, st_ready=1, sb_empty=1, sb_count=0, dm_we=0, dm_addr/dm_wd/dm_pc=0, ld_hit=0, ld_data=0. Entry storage is not cleared.
- Reset mid-operation discards all pending stores; none reach memory.
- Latency: a store accepted at edge N appears on the dm_* outputs during cycle N+1 (if the buffer was empty and drain_en=1) and is written by memory at edge N+1.
- Throughput: 1 push and 1 pop per cycle.
- ld_hit/ld_data are purely combinational in ld_addr and the registered state.
- Pointer wrap: DEPTH-1 → 0; no full/empty ambiguity, because count is authoritative.

## Configuration
- SB_FORWARD_EN defined: forwarding compare logic is present as described.
- Not defined: ld_hit and ld_data are tied to 0. The pipeline must stall loads until sb_empty=1. No compare logic is instantiated.

## Structure
- Package sb_pkg: default DEPTH, a sb_entry_t struct {addr, data, pc}, and the pointer-width localparam derived from DEPTH.
- One sub-module, sb_fwd_match: takes entry addresses, a valid mask, the head/tail pointers and ld_addr; outputs the hit flag and the winning index. Instantiated only under SB_FORWARD_EN.

## Test plan
- Reset, then push 0x10←0xAAAA0001 with drain_en=1 → next cycle dm_we=1, dm_addr=0x10, dm_wd=0xAAAA0001; after that edge sb_empty=1.
- drain_en=0, push 4 stores → sb_count=4 and st_ready=0; a 5th st_valid is not accepted. Set drain_en=1 → stores drain in order over 4 cycles.
- Push 0x20←1, then 0x20←2, drain_en=0, ld_addr=0x22 → ld_hit=1, ld_data=2 (youngest). With SB_FORWARD_EN undefined → ld_hit=0.
- Run 10 push/pop pairs at count=2 → pointers wrap, count stays 2, and the output data order matches the input order.
- With 3 entries pending, assert reset between edges → outputs are immediately 0/empty and no dm_we pulse occurs afterward.
- Full buffer with drain_en=1 and st_valid=1 → pop occurs, push is refused, count goes to DEPTH-1, and st_ready=1 the next cycle.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and defaults for the data-memory store buffer.
package sb_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;
    localparam int unsigned SB_PC_W  = 32;
    localparam int unsigned SB_PTR_W = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [SB_AW-1:0]   addr;
        logic [SB_DW-1:0]   data;
        logic [SB_PC_W-1:0] pc;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search of pending store word addresses against a load address.
import sb_pkg::*;

module sb_fwd_match #(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned WAW   = SB_AW - 2
) (
    input  logic [DEPTH-1:0][WAW-1:0]   ent_waddr,
    input  logic [DEPTH-1:0]            ent_valid,
    input  logic [$clog2(DEPTH)-1:0]    head,
    input  logic [WAW-1:0]              ld_waddr,
    output logic                        hit,
    output logic [$clog2(DEPTH)-1:0]    win_idx
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest from head; a later match overrides an earlier one.
    always_comb begin
        hit     = 1'b0;
        win_idx = head;
        idx     = head;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head + PTR_W'(k);
            if (ent_valid[idx] && (ent_waddr[idx] == ld_waddr)) begin
                hit     = 1'b1;
                win_idx = idx;
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Store buffer in front of the data memory: FIFO of committed stores, one drain per cycle.
// Define SB_FORWARD_EN to enable youngest-match load forwarding; otherwise ld_hit/ld_data are 0.
import sb_pkg::*;

module dm_store_buffer #(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic [31:0]              st_pc,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    input  logic                     drain_en,
    output logic                     dm_we,
    output logic [AW-1:0]            dm_addr,
    output logic [DW-1:0]            dm_wd,
    output logic [31:0]              dm_pc,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t          mem_q [DEPTH];
    sb_entry_t          head_e;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty;
    logic               push;
    logic               pop;

    assign empty    = (count_q == '0);
    assign st_ready = (count_q != CNT_W'(DEPTH));
    assign push     = st_valid & st_ready;
    assign pop      = ~empty & drain_en;

    // Pointers wrap naturally because DEPTH is a power of two; count is authoritative.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{addr: SB_AW'(st_addr), data: SB_DW'(st_data), pc: st_pc};
        end
    end

    assign head_e   = mem_q[head_q];
    assign dm_we    = pop;
    assign dm_addr  = empty ? '0 : AW'(head_e.addr);
    assign dm_wd    = empty ? '0 : DW'(head_e.data);
    assign dm_pc    = empty ? '0 : head_e.pc;
    assign sb_empty = empty;
    assign sb_count = count_q;

`ifdef SB_FORWARD_EN
    logic [DEPTH-1:0][AW-3:0] ent_waddr;
    logic [DEPTH-1:0]         ent_valid;
    logic [PTR_W-1:0]         age;
    logic                     fwd_hit;
    logic [PTR_W-1:0]         fwd_idx;
    logic                     unused_ld_lo;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        ent_waddr = '0;
        ent_valid = '0;
        age       = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            age          = PTR_W'(i) - head_q;
            ent_waddr[i] = (AW-2)'(mem_q[i].addr >> 2);
            ent_valid[i] = ({1'b0, age} < count_q);
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .WAW   (AW - 2)
    ) u_fwd (
        .ent_waddr (ent_waddr),
        .ent_valid (ent_valid),
        .head      (head_q),
        .ld_waddr  (ld_addr[AW-1:2]),
        .hit       (fwd_hit),
        .win_idx   (fwd_idx)
    );

    assign ld_hit       = fwd_hit;
    assign ld_data      = fwd_hit ? DW'(mem_q[fwd_idx].data) : '0;
    assign unused_ld_lo = ^ld_addr[1:0];
`else
    logic unused_ld;

    assign ld_hit    = 1'b0;
    assign ld_data   = '0;
    assign unused_ld = ^ld_addr;
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed plus randomized bench for dm_store_buffer against a queue-based model.
module tb_dm_store_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        drain_en;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic        sb_empty;
    logic [2:0]  sb_count;

    ent_t        q[$];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    logic [31:0] pc_ctr = 32'h0040_0000;

    always #5 clk = ~clk;

    dm_store_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_pc    (st_pc),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .drain_en (drain_en),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .dm_pc    (dm_pc),
        .sb_empty (sb_empty),
        .sb_count (sb_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        e_hit;
        logic [31:0] e_ld;
        int          n;
        n     = q.size();
        e_hit = 1'b0;
        e_ld  = '0;
`ifdef SB_FORWARD_EN
        // Later queue entries are younger, so the last match wins.
        for (int i = 0; i < n; i++) begin
            if (q[i].addr[31:2] == ld_addr[31:2]) begin
                e_hit = 1'b1;
                e_ld  = q[i].data;
            end
        end
`endif
        chk("st_ready", 64'(st_ready), 64'(n < 4));
        chk("sb_count", 64'(sb_count), 64'(n));
        chk("sb_empty", 64'(sb_empty), 64'(n == 0));
        chk("dm_we",    64'(dm_we),    64'((n != 0) && drain_en));
        chk("dm_addr",  64'(dm_addr),  (n != 0) ? 64'(q[0].addr) : 64'd0);
        chk("dm_wd",    64'(dm_wd),    (n != 0) ? 64'(q[0].data) : 64'd0);
        chk("dm_pc",    64'(dm_pc),    (n != 0) ? 64'(q[0].pc)   : 64'd0);
        chk("ld_hit",   64'(ld_hit),   64'(e_hit));
        chk("ld_data",  64'(ld_data),  64'(e_ld));
    endtask

    // Check before the edge, then apply the edge to the model.
    task automatic step();
        logic acc;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            acc = st_valid && (q.size() < 4);
            if ((q.size() != 0) && drain_en) void'(q.pop_front());
            if (acc) q.push_back('{addr: st_addr, data: st_data, pc: st_pc});
        end
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic dr, input logic [31:0] la);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
        drain_en = dr;
        ld_addr  = la;
    endtask

    initial begin
        reset = 1'b1;
        drv(1'b0, '0, '0, 1'b0, '0);
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single store drains the cycle after acceptance.
        drv(1'b1, 32'h10, 32'hAAAA_0001, 1'b1, 32'h10);
        step();
        drv(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
        step();
        step();

        // Fill to full, refuse a fifth store, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 32'h104);
            step();
        end
        drv(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h200);
        step();
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 32'h0, 32'h0, 1'b1, 32'h108);
            step();
        end

        // Same-address stores: youngest forwards, both drain separately.
        drv(1'b1, 32'h20, 32'd1, 1'b0, 32'h22);
        step();
        drv(1'b1, 32'h20, 32'd2, 1'b0, 32'h22);
        step();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 32'h22);
        step();
        drv(1'b0, 32'h0, 32'h0, 1'b1, 32'h23);
        step();
        step();
        step();

        // Steady push/pop at occupancy 2 wraps the pointers.
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 32'h300 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 32'h300);
            step();
        end
        for (int i = 2; i < 12; i++) begin
            drv(1'b1, 32'h300 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b1, 32'h300 + 32'((i - 1) * 4));
            step();
        end
        drv(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        step();
        step();
        step();

        // Reset between edges discards pending stores.
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h400 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1'b0, 32'h400);
            step();
        end
        drv(1'b0, 32'h0, 32'h0, 1'b1, 32'h400);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        check_outputs();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Full buffer with a concurrent pop still refuses the push.
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h500 + 32'(i * 4), 32'hF000_0000 + 32'(i), 1'b0, 32'h508);
            step();
        end
        drv(1'b1, 32'h600, 32'h1234_5678, 1'b1, 32'h600);
        step();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 32'h50C);
        step();
        drv(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic over a narrow address range to exercise forwarding.
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 1)),
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
                $urandom(),
                1'($urandom_range(0, 99) < 45),
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)));
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
